// File: rtl/dmem_bytewise_pkg.sv
// dmem_pkg: shared definitions for the byte-addressable data memory.
//   SIZE_*   : access-size encodings carried on the Size bus.
//   state_t  : clear/idle controller states.
//   addr_err : misalignment / reserved-size decode for one access.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic addr_err(input logic [1:0] size, input logic [1:0] lo);
        logic e;
        e = 1'b0;
        case (size)
            SIZE_HALF: e = lo[0];
            SIZE_WORD: e = (lo != 2'b00);
            SIZE_RSVD: e = 1'b1;
            default:   e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_bytewise_if.sv
// MEM-stage bus of the data memory.
//   WE, A, WD, Size, Unsigned : access request from the pipeline.
//   RD                        : extended load data (combinational).
//   Busy                      : hardware clear in progress, pipeline stalls.
//   AddrErr                   : current access is misaligned or reserved-size.
interface dmem_bytewise_if;
    import dmem_pkg::*;

    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] RD;
    logic        Busy;
    logic        AddrErr;

    modport master (
        output WE, A, WD, Size, Unsigned,
        input  RD, Busy, AddrErr
    );

    modport slave (
        input  WE, A, WD, Size, Unsigned,
        output RD, Busy, AddrErr
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory.
//   Size, ALo  : access size and byte offset A[1:0].
//   WD         : right-aligned store data.
//   Raw        : addressed RAM word.
//   Unsigned   : zero- (1) or sign- (0) extension for sub-word loads.
//   ByteEn     : per-lane write enable, bit n = lane n (lane 0 = bits [31:24]).
//   StoreWord  : store data replicated onto every lane it could occupy.
//   LoadVal    : extracted and extended load value, 0 on error.
//   AddrErr    : misaligned or reserved-size access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  Size,
    input  logic [1:0]  ALo,
    input  logic [31:0] WD,
    input  logic [31:0] Raw,
    input  logic        Unsigned,
    output logic [3:0]  ByteEn,
    output logic [31:0] StoreWord,
    output logic [31:0] LoadVal,
    output logic        AddrErr
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Big-endian lanes: offset 0 is the most significant byte.
        case (ALo)
            2'd0:    byte_sel = Raw[31:24];
            2'd1:    byte_sel = Raw[23:16];
            2'd2:    byte_sel = Raw[15:8];
            default: byte_sel = Raw[7:0];
        endcase
        half_sel = ALo[1] ? Raw[15:0] : Raw[31:16];
    end

    always_comb begin
        AddrErr   = addr_err(Size, ALo);
        ByteEn    = '0;
        StoreWord = WD;
        LoadVal   = '0;
        case (Size)
            SIZE_BYTE: begin
                ByteEn    = 4'b0001 << ALo;
                StoreWord = {4{WD[7:0]}};
                LoadVal   = Unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                ByteEn    = ALo[1] ? 4'b1100 : 4'b0011;
                StoreWord = {2{WD[15:0]}};
                LoadVal   = Unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_WORD: begin
                ByteEn    = 4'b1111;
                LoadVal   = Raw;
            end
            default: begin
                ByteEn    = '0;
                LoadVal   = '0;
            end
        endcase
        if (AddrErr) begin
            ByteEn  = '0;
            LoadVal = '0;
        end
    end

endmodule

// File: rtl/dmem_bytewise.sv
// Byte-addressable MEM-stage data memory with hardware clear after reset.
//   CLK, Reset : clock, synchronous active-high reset.
//   bus        : MEM-stage access bus (store/load, Busy stall, AddrErr).
//   ReadAddr   : debug word index, wraps modulo DEPTH.
//   Data       : debug read data, 0 while clearing.
//   ErrSticky  : set by any qualified erroring access, cleared only by Reset.
module dmem_bytewise
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DBG_AW = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    dmem_bytewise_if.slave    bus,
    input  logic [DBG_AW-1:0] ReadAddr,
    output logic [31:0]       Data,
    output logic              ErrSticky
);

    localparam int AW = $clog2(DEPTH);

    state_t          state, state_n;
    logic [AW-1:0]   idx, idx_n;
    logic            sticky_n;
    logic [31:0]     ram [DEPTH];

    logic [AW-1:0]   widx;
    logic [AW-1:0]   dbg_idx;
    logic [31:0]     ra_ext;
    logic [31:0]     raw;
    logic [3:0]      byte_en;
    logic [31:0]     store_word;
    logic [31:0]     load_val;
    logic            addr_err_w;
    logic            busy;
    logic            store_en;
    logic            err_hit;
    logic            unused_addr_bits;

    assign widx    = bus.A[AW+1:2];
    assign ra_ext  = 32'(ReadAddr);
    assign dbg_idx = ra_ext[AW-1:0];
    assign raw     = ram[widx];
    assign busy    = (state == ST_CLEAR);

    assign unused_addr_bits = ^{bus.A[31:AW+2], ra_ext[31:AW]};

    dmem_lane_align u_align (
        .Size      (bus.Size),
        .ALo       (bus.A[1:0]),
        .WD        (bus.WD),
        .Raw       (raw),
        .Unsigned  (bus.Unsigned),
        .ByteEn    (byte_en),
        .StoreWord (store_word),
        .LoadVal   (load_val),
        .AddrErr   (addr_err_w)
    );

    // Reserved size with WE=0 is an idle bus cycle, not a load attempt.
    assign err_hit  = addr_err_w && (bus.WE || (bus.Size != SIZE_RSVD));
    assign store_en = (state == ST_IDLE) && bus.WE && !addr_err_w;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_CLEAR;
            idx       <= '0;
            ErrSticky <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            ErrSticky <= sticky_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sticky_n = ErrSticky;
        case (state)
            ST_CLEAR: begin
                idx_n = idx + AW'(1);
                if (idx == AW'(DEPTH - 1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                if (err_hit) begin
                    sticky_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (state == ST_CLEAR) begin
                ram[idx] <= '0;
            end else if (store_en) begin
                for (int unsigned l = 0; l < 4; l++) begin
                    if (byte_en[l]) begin
                        ram[widx][31-8*l -: 8] <= store_word[31-8*l -: 8];
                    end
                end
            end
        end
    end

    assign bus.RD      = busy ? '0 : load_val;
    assign bus.Busy    = busy;
    assign bus.AddrErr = addr_err_w;
    assign Data        = busy ? '0 : ram[dbg_idx];

endmodule

// File: tb/tb_dmem_bytewise.sv
module tb_dmem_bytewise;
    import dmem_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        uns;
        logic [5:0]  raddr;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] data;
        logic        sticky;
    } vec_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  ReadAddr;
    logic [31:0] Data;
    logic        ErrSticky;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    dmem_bytewise_if bus ();

    dmem_bytewise #(.DEPTH(64), .DBG_AW(6)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .ReadAddr  (ReadAddr),
        .Data      (Data),
        .ErrSticky (ErrSticky)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] size, input logic uns, input logic [5:0] raddr,
                                input logic chk_rd, input logic [31:0] rd, input logic err,
                                input logic [31:0] data, input logic sticky);
        vec_t v;
        v.we = we; v.a = a; v.wd = wd; v.size = size; v.uns = uns; v.raddr = raddr;
        v.chk_rd = chk_rd; v.rd = rd; v.err = err; v.data = data; v.sticky = sticky;
        vq.push_back(v);
    endfunction

    initial begin
        int n;

        //  we  a        wd           sz         u  ra chk rd           err data         st
        add(1, 32'h10,  32'h11223344, SIZE_WORD, 0, 4, 0, 32'h0,        0, 32'h0,        0);
        add(0, 32'h10,  32'h0,        SIZE_WORD, 0, 4, 1, 32'h11223344, 0, 32'h11223344, 0);
        add(1, 32'h12,  32'h000000AB, SIZE_BYTE, 0, 4, 0, 32'h0,        0, 32'h11223344, 0);
        add(0, 32'h10,  32'h0,        SIZE_WORD, 0, 4, 1, 32'h1122AB44, 0, 32'h1122AB44, 0);
        add(0, 32'h12,  32'h0,        SIZE_BYTE, 0, 4, 1, 32'hFFFFFFAB, 0, 32'h1122AB44, 0);
        add(0, 32'h12,  32'h0,        SIZE_BYTE, 1, 4, 1, 32'h000000AB, 0, 32'h1122AB44, 0);
        add(0, 32'h13,  32'h0,        SIZE_BYTE, 0, 4, 1, 32'h00000044, 0, 32'h1122AB44, 0);
        add(0, 32'h10,  32'h0,        SIZE_BYTE, 0, 4, 1, 32'h00000011, 0, 32'h1122AB44, 0);
        add(0, 32'h10,  32'h0,        SIZE_HALF, 0, 4, 1, 32'h00001122, 0, 32'h1122AB44, 0);
        add(0, 32'h10,  32'h0,        SIZE_RSVD, 0, 4, 1, 32'h0,        1, 32'h1122AB44, 0);
        add(1, 32'h22,  32'h00008001, SIZE_HALF, 0, 8, 0, 32'h0,        0, 32'h0,        0);
        add(0, 32'h22,  32'h0,        SIZE_HALF, 0, 8, 1, 32'hFFFF8001, 0, 32'h00008001, 0);
        add(0, 32'h22,  32'h0,        SIZE_HALF, 1, 8, 1, 32'h00008001, 0, 32'h00008001, 0);
        add(0, 32'h20,  32'h0,        SIZE_WORD, 0, 8, 1, 32'h00008001, 0, 32'h00008001, 0);
        add(1, 32'h20,  32'h00001234, SIZE_HALF, 0, 8, 0, 32'h0,        0, 32'h00008001, 0);
        add(0, 32'h20,  32'h0,        SIZE_WORD, 1, 8, 1, 32'h12348001, 0, 32'h12348001, 0);
        add(0, 32'h20,  32'h0,        SIZE_BYTE, 0, 8, 1, 32'h00000012, 0, 32'h12348001, 0);
        add(1, 32'h05,  32'hDEADBEEF, SIZE_WORD, 0, 1, 1, 32'h0,        1, 32'h0,        0);
        add(0, 32'h04,  32'h0,        SIZE_WORD, 0, 1, 1, 32'h0,        0, 32'h0,        1);
        add(1, 32'h100, 32'hCAFEF00D, SIZE_WORD, 0, 0, 0, 32'h0,        0, 32'h0,        1);
        add(0, 32'h0,   32'h0,        SIZE_WORD, 0, 0, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1);
        add(0, 32'h11,  32'h0,        SIZE_HALF, 0, 0, 1, 32'h0,        1, 32'hCAFEF00D, 1);
        add(1, 32'h23,  32'h0000FFFF, SIZE_HALF, 0, 8, 1, 32'h0,        1, 32'h12348001, 1);
        add(0, 32'h20,  32'h0,        SIZE_WORD, 0, 8, 1, 32'h12348001, 0, 32'h12348001, 1);

        bus.WE = 1'b0; bus.A = '0; bus.WD = '0; bus.Size = SIZE_WORD; bus.Unsigned = 1'b0;
        ReadAddr = '0;

        // Power-up reset held for two edges, then the full clear.
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        chk("busy_after_reset", 32'(bus.Busy), 32'h1);
        chk("sticky_after_reset", 32'(ErrSticky), 32'h0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (!bus.Busy) break;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd64);

        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            ReadAddr = 6'(i);
            #1 chk($sformatf("clear_word%0d", i), Data, 32'h0);
        end

        foreach (vq[i]) begin
            @(posedge CLK);
            #1;
            bus.WE = vq[i].we; bus.A = vq[i].a; bus.WD = vq[i].wd;
            bus.Size = vq[i].size; bus.Unsigned = vq[i].uns; ReadAddr = vq[i].raddr;
            @(negedge CLK);
            if (vq[i].chk_rd) chk($sformatf("v%0d_rd", i), bus.RD, vq[i].rd);
            chk($sformatf("v%0d_err", i), 32'(bus.AddrErr), 32'(vq[i].err));
            chk($sformatf("v%0d_data", i), Data, vq[i].data);
            chk($sformatf("v%0d_sticky", i), 32'(ErrSticky), 32'(vq[i].sticky));
        end

        // Reset re-asserted part-way through a clear restarts the full sweep.
        @(posedge CLK);
        #1 bus.WE = 1'b0; Reset = 1'b1;
        @(posedge CLK);
        #1 Reset = 1'b0;
        repeat (30) @(posedge CLK);
        #1 Reset = 1'b1;
        chk("busy_mid_clear", 32'(bus.Busy), 32'h1);
        @(posedge CLK);
        #1 Reset = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (c == 0) chk("sticky_cleared", 32'(ErrSticky), 32'h0);
            if (!bus.Busy) break;
            n++;
            if (c == 10) begin
                bus.WE = 1'b1; bus.A = 32'h0; bus.WD = 32'h12345678;
                bus.Size = SIZE_WORD; ReadAddr = '0;
                #1;
                chk("busy_rd_zero", bus.RD, 32'h0);
                chk("busy_data_zero", Data, 32'h0);
            end else if (c == 11) begin
                bus.A = 32'h1;
                #1 chk("busy_addrerr", 32'(bus.AddrErr), 32'h1);
            end else if (c == 12) begin
                bus.WE = 1'b0; bus.A = 32'h0;
            end
        end
        chk("restart_cycles", 32'(n), 32'd64);
        #1;
        chk("busy_store_ignored", Data, 32'h0);
        chk("busy_load_word0", bus.RD, 32'h0);
        chk("busy_err_ignored", 32'(ErrSticky), 32'h0);
        chk("idle_after_clear", 32'(bus.Busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
